ift_trace_capture: RTL
======================

Name: ift_trace_capture

Overview:
- Synthesizable monitor at the output side of an IFT-instrumented DUT; complements the file-driven stimulus player.
- Each cycle it samples the DUT data output and its 32-bit taint vector. On a trigger it records change-compressed entries into an internal buffer.
- After capture it drains the buffer in order over a valid/ready read port for offline taint-flow checking.

Parameters:
- DATA_W, 2, width of sampled DUT data (Q).
- TAINT_W, 32, width of sampled taint vector (Q_t).
- DEPTH, 16, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  capture and read clock.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  level; enables capture session.
- trig  in  1  starts recording while ARMED.
- data_in  in  DATA_W  sampled DUT data.
- taint_in  in  TAINT_W  sampled DUT taint.
- rd_valid  out  1  entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_data  out  DATA_W  entry data field.
- rd_taint  out  TAINT_W  entry taint field.
- rd_ts  out  16  entry timestamp (see Optional Feature).
- rd_last  out  1  current entry is final one.
- busy  out  1  state != IDLE.
- count  out  $clog2(DEPTH)+1  entries currently stored.

Behaviour:
- Reset: state=IDLE, rd_valid=0, rd_last=0, busy=0, count=0, rd_data/rd_taint/rd_ts=0, timestamp=0, write/read pointers=0.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: arm=1 -> ARMED. Timestamp is cleared on that transition.
- ARMED:
  - arm=0 -> IDLE.
  - trig=1 (with arm=1) -> CAPTURE. The sample present in the trig cycle is written as entry 0.
- CAPTURE:
  - Write a new entry in any cycle where {data_in, taint_in} differs from the last written entry.
  - At most one write per cycle. Visible in count one cycle later.
  - Exit to DRAIN when count reaches DEPTH (the write filling the last slot happens; no further writes), or when arm=0. In the arm=0 cycle no write occurs.
- DRAIN:
  - rd_valid=1 while entries remain. Fields come from the read pointer (combinational read), in write order.
  - Handshake is complete when rd_valid&rd_ready. The read pointer advances and count decrements.
  - Fields stay stable while rd_valid&!rd_ready.
  - rd_last=1 together with rd_valid on the entry where count==1.
  - The handshake on the last entry -> IDLE next cycle, pointers=0.
- Timestamp: 16-bit free-running counter of cycles since the ARMED entry. Saturates at 0xFFFF (no wrap).
- trig is ignored outside ARMED. arm is ignored in DRAIN; the drain always completes.
- Re-arm is possible only after returning to IDLE. arm held high through DRAIN -> ARMED one cycle after IDLE.
- Asserting rst at any time aborts the session and returns all state to reset values; buffer contents are discarded.

Optional Feature:
- Macro IFT_CAPTURE_TIMESTAMP_EN.
- Defined: each entry stores the timestamp at its write cycle, and rd_ts presents it.
- Undefined: no timestamp storage or counter; rd_ts is tied to 0. Entry width is DATA_W+TAINT_W.

Decomposition:
- Package ift_trace_pkg:
  - state enum (IDLE/ARMED/CAPTURE/DRAIN).
  - TS_W=16.
  - entry width function of DATA_W, TAINT_W and the timestamp option.
- One sub-module ift_trace_mem:
  - DEPTH x entry-width register array.
  - Synchronous write, combinational read.
  - No reset on contents.

Test Plan:
- Reset mid-DRAIN (rst pulse while rd_valid=1, count=3) -> next cycle busy=0, rd_valid=0, count=0.
- Change compression: arm, trig at t0 with data=00/taint=0; hold 3 cycles; then data=11/taint=0x4 -> exactly 2 entries. Drain gives (00,0x0,ts=1) then (11,0x4,ts=4) with rd_last on the second (timestamp build).
- Full: 20 consecutive distinct samples after trig -> count=16, automatic DRAIN, 16 entries in order, samples 17-20 absent.
- Backpressure: rd_ready low 5 cycles with rd_valid=1 -> rd_data/rd_taint/rd_ts unchanged. Raising rd_ready for 1 cycle advances exactly one entry.
- Arm drop: arm=0 in ARMED without trig -> IDLE, count=0, no rd_valid. arm=0 in CAPTURE after 2 entries -> DRAIN of 2 entries.
- Trig outside ARMED (IDLE and DRAIN) -> no entries written, count unchanged.

Source files
------------

// File: rtl/ift_trace_pkg.sv
// Shared types and sizing for the IFT trace capture block.
// Entry width grows by TS_W when IFT_CAPTURE_TIMESTAMP_EN is defined.
package ift_trace_pkg;

    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    function automatic int entry_w(input int data_w, input int taint_w);
`ifdef IFT_CAPTURE_TIMESTAMP_EN
        return data_w + taint_w + TS_W;
`else
        return data_w + taint_w;
`endif
    endfunction

endpackage

// File: rtl/ift_trace_capture_if.sv
// Read port of the trace buffer: valid/ready handshake plus entry fields.
interface ift_trace_capture_if #(
    parameter int DATA_W  = 2,
    parameter int TAINT_W = 32
);
    import ift_trace_pkg::*;

    logic               rd_valid;
    logic               rd_ready;
    logic [DATA_W-1:0]  rd_data;
    logic [TAINT_W-1:0] rd_taint;
    logic [TS_W-1:0]    rd_ts;
    logic               rd_last;

    modport master (
        output rd_valid, rd_data, rd_taint, rd_ts, rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_data, rd_taint, rd_ts, rd_last,
        output rd_ready
    );

endinterface

// File: rtl/ift_trace_mem.sv
// Trace entry storage: synchronous write, combinational read, contents not reset.
module ift_trace_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ift_trace_capture.sv
// Change-compressed trace capture of DUT data/taint with in-order drain port.
// Optional per-entry timestamps: define IFT_CAPTURE_TIMESTAMP_EN.
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | waiting for trig, timestamp running
//   CAPTURE | recording samples that differ from the last entry
//   DRAIN   | presenting stored entries on the read port
module ift_trace_capture
    import ift_trace_pkg::*;
#(
    parameter int DATA_W  = 2,
    parameter int TAINT_W = 32,
    parameter int DEPTH   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_arm,
    input  logic                     i_trig,
    input  logic [DATA_W-1:0]        i_data_in,
    input  logic [TAINT_W-1:0]       i_taint_in,
    ift_trace_capture_if.master      rd,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DATA_W + TAINT_W;
    localparam int EW = entry_w(DATA_W, TAINT_W);
    localparam logic [CW-1:0] C_LAST_FREE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] C_ONE       = CW'(1);

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_last_smp;

    logic [SW-1:0]   w_smp;
    logic            w_changed;
    logic            w_we;
    logic            w_valid;
    logic [EW-1:0]   w_wentry;
    logic [EW-1:0]   w_rentry;

    assign w_smp     = {i_data_in, i_taint_in};
    assign w_changed = (w_smp != r_last_smp);
    // The trig-cycle sample is always stored; later samples only when they change.
    assign w_we      = i_arm && (((r_state == ST_ARMED) && i_trig) ||
                                 ((r_state == ST_CAPTURE) && w_changed));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_smp <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!i_arm) begin
                        r_state <= ST_IDLE;
                    end else if (i_trig) begin
                        r_state    <= ST_CAPTURE;
                        r_wr_ptr   <= AW'(1);
                        r_count    <= C_ONE;
                        r_last_smp <= w_smp;
                    end
                end
                ST_CAPTURE: begin
                    if (!i_arm) begin
                        r_state <= ST_DRAIN;
                    end else if (w_changed) begin
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        r_count    <= r_count + 1'b1;
                        r_last_smp <= w_smp;
                        if (r_count == C_LAST_FREE) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd.rd_ready) begin
                        if (r_count == C_ONE) begin
                            r_state  <= ST_IDLE;
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                            r_count  <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            r_count  <= r_count - 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef IFT_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ts <= '0;
        end else if ((r_state == ST_IDLE) && i_arm) begin
            r_ts <= '0;
        end else if (r_ts != '1) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wentry  = {r_ts, w_smp};
    assign rd.rd_ts  = w_valid ? w_rentry[EW-1 -: TS_W] : '0;
`else
    assign w_wentry  = w_smp;
    assign rd.rd_ts  = '0;
`endif

    ift_trace_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rentry)
    );

    // DRAIN is only ever entered with at least one entry stored.
    assign w_valid     = (r_state == ST_DRAIN);
    assign rd.rd_valid = w_valid;
    assign rd.rd_last  = w_valid && (r_count == C_ONE);
    assign rd.rd_data  = w_valid ? w_rentry[SW-1:TAINT_W] : '0;
    assign rd.rd_taint = w_valid ? w_rentry[TAINT_W-1:0] : '0;

    assign o_busy  = (r_state != ST_IDLE);
    assign o_count = r_count;

endmodule
